// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, SYSTEM serialization, branch resolve wait.
// Stall/bubble/flush are combinational in the same cycle; MEM_STALL freezes all controller state.
module hazard_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] DE_IR,
  input  logic        DE_V,
  input  logic [31:0] EXE_IR,
  input  logic        EXE_V,
  input  logic [4:0]  EXE_DRID,
  input  logic        MEM_STALL,
  input  logic        EXE_BR_DONE,
  input  logic        EXE_BR_TAKEN,
  output logic        DE_STALL,
  output logic        DE_BUBBLE,
  output logic        FE_FLUSH,
  output logic [1:0]  CTRL_STATE,
  output logic [15:0] STALL_CNT
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    BR_WAIT = 2'd2,
    SERIAL  = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ser_cnt;
  logic [15:0] r_stall_cnt;

  logic [6:0] w_de_op;
  logic [6:0] w_ex_op;
  logic       w_rs1_used;
  logic       w_rs2_used;
  logic       w_ldhaz;
  logic       w_de_sys;
  logic       w_de_br;
  logic       w_stall;
  logic       w_bubble;
  logic       w_flush;
  logic       w_unused_ir;

  assign w_de_op = DE_IR[6:0];
  assign w_ex_op = EXE_IR[6:0];

  // LUI, AUIPC and JAL carry immediate bits where rs1 would sit.
  assign w_rs1_used = !(w_de_op == 7'b0110111 || w_de_op == 7'b0010111 ||
                        w_de_op == 7'b1101111);
  assign w_rs2_used = (w_de_op == 7'b0110011) || (w_de_op == 7'b0111011) ||
                      (w_de_op == 7'b0100011) || (w_de_op == 7'b1100011);

  assign w_ldhaz = EXE_V && (w_ex_op == OP_LOAD) && (EXE_DRID != 5'd0) && DE_V &&
                   ((w_rs1_used && (EXE_DRID == DE_IR[19:15])) ||
                    (w_rs2_used && (EXE_DRID == DE_IR[24:20])));
  assign w_de_sys = DE_V && (w_de_op == OP_SYSTEM);
  assign w_de_br  = DE_V && (w_de_op == OP_BRANCH);

  assign w_unused_ir = &{1'b0, DE_IR[31:25], DE_IR[14:7], EXE_IR[31:7]};

  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (reset) begin
      w_stall = 1'b0;
    end else if (MEM_STALL) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        RUN, LDUSE: begin
          if (w_ldhaz || w_de_sys) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
        SERIAL: begin
          if (r_ser_cnt != 2'd0) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
        BR_WAIT: begin
          w_bubble = 1'b1;
          if (EXE_BR_DONE && EXE_BR_TAKEN) w_flush = 1'b1;
          else                             w_stall = 1'b1;
        end
        default: w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= RUN;
      r_ser_cnt   <= 2'd0;
      r_stall_cnt <= 16'd0;
    end else if (!MEM_STALL) begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      case (r_state)
        RUN, LDUSE: begin
          if (w_ldhaz) begin
            r_state <= LDUSE;
          end else if (w_de_sys) begin
            r_ser_cnt <= 2'd2;
            r_state   <= SERIAL;
          end else if (w_de_br) begin
            r_state <= BR_WAIT;
          end else begin
            r_state <= RUN;
          end
        end
        SERIAL: begin
          if (r_ser_cnt != 2'd0) r_ser_cnt <= r_ser_cnt - 2'd1;
          else                   r_state   <= RUN;
        end
        BR_WAIT: begin
          if (EXE_BR_DONE) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign DE_STALL   = w_stall;
  assign DE_BUBBLE  = w_bubble;
  assign FE_FLUSH   = w_flush;
  assign CTRL_STATE = r_state;
  assign STALL_CNT  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle comparison against a bubble-accounting model
// plus literal expectations at the interesting cycles.
module tb_hazard_ctrl;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_BR = 7'b1100011, OP_SYS = 7'b1110011;
  localparam logic [6:0] OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] CSRRW = 32'h3401_1073;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] DE_IR = NOP;
  logic        DE_V = 1'b0;
  logic [31:0] EXE_IR = NOP;
  logic        EXE_V = 1'b0;
  logic [4:0]  EXE_DRID = 5'd0;
  logic        MEM_STALL = 1'b0;
  logic        EXE_BR_DONE = 1'b0;
  logic        EXE_BR_TAKEN = 1'b0;
  logic        DE_STALL, DE_BUBBLE, FE_FLUSH;
  logic [1:0]  CTRL_STATE;
  logic [15:0] STALL_CNT;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK(CLK), .reset(reset), .DE_IR(DE_IR), .DE_V(DE_V), .EXE_IR(EXE_IR), .EXE_V(EXE_V),
    .EXE_DRID(EXE_DRID), .MEM_STALL(MEM_STALL), .EXE_BR_DONE(EXE_BR_DONE),
    .EXE_BR_TAKEN(EXE_BR_TAKEN), .DE_STALL(DE_STALL), .DE_BUBBLE(DE_BUBBLE),
    .FE_FLUSH(FE_FLUSH), .CTRL_STATE(CTRL_STATE), .STALL_CNT(STALL_CNT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  // Model: tracks which wait the controller is in and how many SYSTEM bubbles were given.
  bit     m_live = 0, m_ld = 0, m_br = 0;
  int     m_sys_given = 0;
  longint m_stalls = 0;
  bit     n_ld, n_br;
  int     n_sys_given;
  longint n_stalls;

  always @(negedge CLK) begin
    logic [6:0] dop, eop;
    bit rs1u, rs2u, haz, e_st, e_bu, e_fl;
    int e_state;
    dop  = DE_IR[6:0];
    eop  = EXE_IR[6:0];
    rs1u = !(dop inside {7'b0110111, 7'b0010111, 7'b1101111});
    rs2u = dop inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
    haz  = EXE_V && eop == OP_LOAD && EXE_DRID != 0 && DE_V &&
           ((rs1u && EXE_DRID == DE_IR[19:15]) || (rs2u && EXE_DRID == DE_IR[24:20]));
    e_st = 0; e_bu = 0; e_fl = 0;
    n_ld = m_ld; n_br = m_br; n_sys_given = m_sys_given; n_stalls = m_stalls;
    if (reset) begin
      n_ld = 0; n_br = 0; n_sys_given = 0; n_stalls = 0;
    end else if (MEM_STALL) begin
      e_st = 1;
    end else if (m_br) begin
      e_bu = 1;
      if (EXE_BR_DONE && EXE_BR_TAKEN) e_fl = 1; else e_st = 1;
      n_br = !EXE_BR_DONE;
    end else if (m_sys_given != 0) begin
      if (m_sys_given < 3) begin e_st = 1; e_bu = 1; n_sys_given = m_sys_given + 1; end
      else n_sys_given = 0;
    end else begin
      n_ld = 0;
      if (haz) begin e_st = 1; e_bu = 1; n_ld = 1; end
      else if (DE_V && dop == OP_SYS) begin e_st = 1; e_bu = 1; n_sys_given = 1; end
      else if (DE_V && dop == OP_BR) n_br = 1;
    end
    if (!reset && !MEM_STALL && e_st) n_stalls = m_stalls + 1;
    chk("m_stall", DE_STALL, e_st);
    chk("m_bubble", DE_BUBBLE, e_bu);
    chk("m_flush", FE_FLUSH, e_fl);
    if (m_live) begin
      e_state = m_br ? 2 : (m_sys_given != 0) ? 3 : m_ld ? 1 : 0;
      chk("m_state", CTRL_STATE, e_state);
      chk("m_cnt", STALL_CNT, (m_stalls > 65535) ? 32'hFFFF : 32'(m_stalls));
    end
  end

  always @(posedge CLK) begin
    if (reset) m_live = 1;
    m_ld = n_ld; m_br = n_br; m_sys_given = n_sys_given; m_stalls = n_stalls;
  end

  task automatic cyc();
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cycle(input string nm, input bit st, input bit bu, input bit fl,
                           input int cs, input int cnt);
    @(negedge CLK);
    chk({nm, "_stall"}, DE_STALL, st);
    chk({nm, "_bubble"}, DE_BUBBLE, bu);
    chk({nm, "_flush"}, FE_FLUSH, fl);
    chk({nm, "_state"}, CTRL_STATE, cs);
    chk({nm, "_cnt"}, STALL_CNT, cnt);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; DE_V = 0; EXE_V = 0; MEM_STALL = 0; EXE_BR_DONE = 0; EXE_BR_TAKEN = 0;
    DE_IR = NOP; EXE_IR = NOP; EXE_DRID = 0;
    cyc(); cyc();
    reset = 0;
  endtask

  initial begin
    #1;
    cyc();
    chk_cycle("reset", 0, 0, 0, 0, 0);
    reset = 0;

    // load-use on rs1
    EXE_IR = mk(OP_LOAD, 5, 2, 0); EXE_V = 1; EXE_DRID = 5;
    DE_IR = mk(OP_REG, 6, 5, 1); DE_V = 1;
    chk_cycle("lu_hit", 1, 1, 0, 0, 0);
    EXE_V = 0;
    chk_cycle("lu_issue", 0, 0, 0, 1, 1);
    EXE_IR = mk(OP_REG, 6, 5, 1); EXE_V = 1; EXE_DRID = 6; DE_IR = NOP;
    chk_cycle("lu_after", 0, 0, 0, 0, 1);

    // x0 destination, unused rs2 field, used rs2, DE_V=0, LUI rs1 field
    EXE_IR = mk(OP_LOAD, 0, 2, 0); EXE_DRID = 0; DE_IR = mk(OP_REG, 1, 0, 0);
    chk_cycle("x0", 0, 0, 0, 0, 1);
    EXE_IR = mk(OP_LOAD, 7, 2, 0); EXE_DRID = 7; DE_IR = mk(OP_IMM, 1, 0, 7);
    chk_cycle("addi_rs2", 0, 0, 0, 0, 1);
    DE_IR = mk(OP_ST, 0, 2, 7);
    chk_cycle("sw_rs2", 1, 1, 0, 0, 1);
    EXE_V = 0;
    chk_cycle("sw_issue", 0, 0, 0, 1, 2);
    EXE_V = 1; DE_IR = mk(OP_REG, 1, 7, 7); DE_V = 0;
    chk_cycle("dev0", 0, 0, 0, 0, 2);
    DE_IR = mk(OP_LUI, 1, 7, 0); DE_V = 1;
    chk_cycle("lui", 0, 0, 0, 0, 2);

    // CSR serialization
    do_reset();
    DE_IR = CSRRW; DE_V = 1;
    chk_cycle("csr_b1", 1, 1, 0, 0, 0);
    chk_cycle("csr_b2", 1, 1, 0, 3, 1);
    chk_cycle("csr_b3", 1, 1, 0, 3, 2);
    chk_cycle("csr_iss", 0, 0, 0, 3, 3);
    DE_IR = NOP;
    chk_cycle("csr_run", 0, 0, 0, 0, 3);

    do_reset();
    DE_IR = CSRRW; DE_V = 1;
    chk_cycle("csrm_b1", 1, 1, 0, 0, 0);
    MEM_STALL = 1;
    chk_cycle("csrm_hold", 1, 0, 0, 3, 1);
    MEM_STALL = 0;
    chk_cycle("csrm_b2", 1, 1, 0, 3, 1);
    chk_cycle("csrm_b3", 1, 1, 0, 3, 2);
    chk_cycle("csrm_iss", 0, 0, 0, 3, 3);
    DE_IR = NOP;
    chk_cycle("csrm_run", 0, 0, 0, 0, 3);

    // branch taken, then not taken
    do_reset();
    DE_IR = mk(OP_BR, 0, 1, 2); DE_V = 1;
    chk_cycle("br_iss", 0, 0, 0, 0, 0);
    EXE_IR = mk(OP_BR, 0, 1, 2); EXE_V = 1; DE_IR = NOP;
    chk_cycle("br_wait", 1, 1, 0, 2, 0);
    EXE_BR_DONE = 1; EXE_BR_TAKEN = 1;
    chk_cycle("br_tk", 0, 1, 1, 2, 1);
    EXE_BR_DONE = 0; EXE_BR_TAKEN = 0; EXE_V = 0; DE_V = 0;
    chk_cycle("br_tk_run", 0, 0, 0, 0, 1);
    DE_IR = mk(OP_BR, 0, 1, 2); DE_V = 1;
    chk_cycle("brn_iss", 0, 0, 0, 0, 1);
    EXE_IR = mk(OP_BR, 0, 1, 2); EXE_V = 1; DE_IR = mk(OP_REG, 3, 1, 2);
    chk_cycle("brn_wait", 1, 1, 0, 2, 1);
    EXE_BR_DONE = 1;
    chk_cycle("brn_nt", 1, 1, 0, 2, 2);
    EXE_BR_DONE = 0; EXE_V = 0;
    chk_cycle("brn_held", 0, 0, 0, 0, 3);

    // saturation, then reset mid-BR_WAIT
    do_reset();
    DE_IR = mk(OP_BR, 0, 1, 2); DE_V = 1;
    cyc();
    DE_IR = NOP;
    repeat (70000) cyc();
    chk_cycle("sat", 1, 1, 0, 2, 16'hFFFF);
    repeat (3) cyc();
    chk_cycle("sat_hold", 1, 1, 0, 2, 16'hFFFF);
    reset = 1;
    chk_cycle("rst_br", 0, 0, 0, 2, 16'hFFFF);
    reset = 0; DE_V = 0;
    chk_cycle("rst_br_after", 0, 0, 0, 0, 0);

    // reset while SERIAL counter is 1
    DE_IR = CSRRW; DE_V = 1;
    cyc(); cyc();
    reset = 1;
    chk_cycle("rst_ser", 0, 0, 0, 3, 2);
    reset = 0; DE_V = 0;
    chk_cycle("rst_ser_after", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named CLK and reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 DE_IR  input  32  instruction in the DE latch.
REQ-005 DE_V  input  1  DE latch valid.
REQ-006 EXE_IR  input  32  instruction in the EXE latch.
REQ-007 EXE_V  input  1  EXE latch valid.
REQ-008 EXE_DRID  input  5  destination register of the EXE instruction.
REQ-009 MEM_STALL  input  1  memory stage is holding the whole pipe.
REQ-010 EXE_BR_DONE  input  1  branch in EXE resolved this cycle.
REQ-011 EXE_BR_TAKEN  input  1  resolved branch is taken; qualified by EXE_BR_DONE.
REQ-012 DE_STALL  output  1  hold the FE PC and DE latch (combinational).
REQ-013 DE_BUBBLE  output  1  load EXE with EXE_V=0 instead of DE (combinational).
REQ-014 FE_FLUSH  output  1  invalidate the DE latch and wrong-path fetch (combinational).
REQ-015 CTRL_STATE  output  2  registered FSM state: RUN=0, LDUSE=1, BR_WAIT=2, SERIAL=3.
REQ-016 STALL_CNT  output  16  registered saturating count of controller-caused stall cycles.

Function
REQ-017 Opcode classes are decoded on bits [6:0]: LOAD 0000011, BRANCH 1100011, SYSTEM 1110011.
REQ-018 rs1 is used unless the DE opcode is 0110111, 0010111 or 1101111.
REQ-019 rs2 is used only for DE opcodes 0110011, 0111011, 0100011 and 1100011.
REQ-020 LDHAZ = EXE_V & EXE LOAD & EXE_DRID!=0 & DE_V & (rs1-used & EXE_DRID==DE_IR[19:15] | rs2-used & EXE_DRID==DE_IR[24:20]).
REQ-021 MEM_STALL=1 has top priority: DE_STALL=1, DE_BUBBLE=0, FE_FLUSH=0; state, the serial counter and STALL_CNT all hold.
REQ-022 RUN/LDUSE with LDHAZ: DE_STALL=1, DE_BUBBLE=1; next state LDUSE.
REQ-023 RUN/LDUSE, no LDHAZ, DE_V and SYSTEM: DE_STALL=1, DE_BUBBLE=1; load the 2-bit serial counter with 2; next state SERIAL.
REQ-024 RUN/LDUSE, no LDHAZ, DE_V and BRANCH: issue with all outputs 0; next state BR_WAIT.
REQ-025 RUN/LDUSE, all other cases: all outputs 0; next state RUN.
REQ-026 LDUSE has exactly the outputs and transitions of RUN; it exists for observability only.
REQ-027 SERIAL with counter !=0: DE_STALL=1, DE_BUBBLE=1; decrement the counter.
REQ-028 SERIAL with counter ==0: all outputs 0 (the SYSTEM instruction issues); next state RUN.
REQ-029 A SYSTEM instruction therefore issues after exactly 3 bubble cycles when MEM_STALL=0 throughout.
REQ-030 BR_WAIT with EXE_BR_DONE=0: DE_STALL=1, DE_BUBBLE=1; stay in BR_WAIT.
REQ-031 BR_WAIT with EXE_BR_DONE=1 and EXE_BR_TAKEN=1: FE_FLUSH=1, DE_BUBBLE=1, DE_STALL=0; next state RUN.
REQ-032 BR_WAIT with EXE_BR_DONE=1 and EXE_BR_TAKEN=0: DE_STALL=1, DE_BUBBLE=1; next state RUN, which re-evaluates the held instruction.
REQ-033 FE_FLUSH SHALL be asserted only in BR_WAIT on a taken resolution.
REQ-034 STALL_CNT increments on each cycle with DE_STALL=1 and MEM_STALL=0, and saturates at 16'hFFFF.
REQ-035 When DE_V=0 in RUN/LDUSE, LDHAZ, SYSTEM and BRANCH detection are all suppressed.

Reset
REQ-036 While reset=1: DE_STALL=0, DE_BUBBLE=0 and FE_FLUSH=0, overriding all other rules.
REQ-037 On a clock edge with reset=1: CTRL_STATE=RUN, serial counter=0, STALL_CNT=0.
REQ-038 Reset asserted in any state, including mid-SERIAL or mid-BR_WAIT, returns to RUN on the next edge with no pending bubbles.

Verification
REQ-039 Load-use: EXE=LW x5; DE=ADD x6,x5,x1 -> one cycle with DE_STALL=1, DE_BUBBLE=1; CTRL_STATE=1; ADD issues on the next cycle; STALL_CNT=1.
REQ-040 x0 and rs2 checks:
- EXE=LW x0 with DE reading x0 -> no stall.
- EXE=LW x7 with DE=ADDI reading x0, and DE_IR[24:20]=7 -> no stall.
REQ-041 CSR serialization: DE=CSRRW -> 3 consecutive bubble cycles, then issue on the 4th cycle; STALL_CNT=3.
- Repeat with MEM_STALL=1 in the 2nd cycle -> issue on the 5th cycle; STALL_CNT still 3.
REQ-042 Branch: DE=BEQ issues -> BR_WAIT.
- EXE_BR_DONE=1, EXE_BR_TAKEN=1 -> FE_FLUSH=1, DE_BUBBLE=1 for one cycle, then RUN.
- Not-taken case -> one bubble cycle, then the held instruction issues.
REQ-043 Saturation and reset:
- Force 70000 stall cycles -> STALL_CNT=16'hFFFF and holds.
- Assert reset during SERIAL with counter=1 -> next cycle CTRL_STATE=0, STALL_CNT=0, all outputs 0.
